// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and the IF/ID pipeline register layout.
// Widths, word size and the NOP returned for out-of-range fetches.
package fetch_stage_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;
   localparam logic [XLEN-1:0] NOP_INSTR  = 32'hE1A0_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            vld;
   } if_id_t;

endpackage

// File: rtl/fetch_stage_inst_mem.sv
// Instruction ROM: IMEM_DEPTH words, image supplied as MEM_INIT (built from the program hex).
// Latency: combinational lookup by word index; no handshake.
// Backpressure: none; indices past the end return NOP instead of aliasing.
module inst_mem
   import fetch_stage_pkg::*;
#(
   parameter int                         IMEM_DEPTH = 64,
   parameter logic [IMEM_DEPTH*XLEN-1:0] MEM_INIT   = '0
) (
   input  logic [XLEN-3:0] word_idx,
   output logic [XLEN-1:0] instr
);

   localparam int              AW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int              DEPTH_I = IMEM_DEPTH;
   localparam logic [XLEN-3:0] DEPTH_W = DEPTH_I[XLEN-3:0];

   logic [XLEN-1:0] rom [IMEM_DEPTH];

   for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
      assign rom[i] = MEM_INIT[i*XLEN +: XLEN];
   end

   // Full-width compare so high PC bits never wrap back into the array.
   always_comb begin
      instr = NOP_INSTR;
      if (word_idx < DEPTH_W) begin
         instr = rom[word_idx[AW-1:0]];
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction ROM lookup and IF/ID register (optional FETCH_STALL_CNT_EN).
// Latency: one cycle from fetch address to IF/ID.
// Backpressure: freeze holds PC and IF/ID; Branch_taken overrides freeze, flush inserts a bubble.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                         IMEM_DEPTH = 64,
   parameter logic [XLEN-1:0]            RESET_PC   = 32'h0000_0000,
   parameter logic [IMEM_DEPTH*XLEN-1:0] IMEM_INIT  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            Branch_taken,
   input  logic [XLEN-1:0] Branch_Address,
   input  logic            flush,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [XLEN-1:0] IF_ID_Instruction,
   output logic            IF_ID_valid,
   output logic [XLEN-1:0] PC_out
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [XLEN-1:0] Stall_count
`endif
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] fetch_instr;
   if_id_t          if_id_q;

   assign pc_plus4 = pc_q + WORD_BYTES;

   inst_mem #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .MEM_INIT   (IMEM_INIT)
   ) u_inst_mem (
      .word_idx (pc_q[XLEN-1:2]),
      .instr    (fetch_instr)
   );

   // A redirect must win over a stall, otherwise the branch would be lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else if (Branch_taken) begin
         pc_q <= Branch_Address;
      end else if (!freeze) begin
         pc_q <= pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_id_q <= '0;
      end else if (flush) begin
         if_id_q <= '0;
      end else if (!freeze) begin
         if_id_q <= '{pc: pc_plus4, instr: fetch_instr, vld: 1'b1};
      end
   end

   assign IF_ID_PC          = if_id_q.pc;
   assign IF_ID_Instruction = if_id_q.instr;
   assign IF_ID_valid       = if_id_q.vld;
   assign PC_out            = pc_q;

`ifdef FETCH_STALL_CNT_EN
   logic [XLEN-1:0] stall_cnt_q;

   // Only cycles where the PC actually held count as stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (freeze && !Branch_taken && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign Stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// control traffic checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam int DEPTH = 16;
   localparam logic [31:0] NOP = 32'hE1A0_0000;

   function automatic logic [DEPTH*32-1:0] build_img();
      logic [DEPTH*32-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) v[i*32 +: 32] = 32'h1234_0000 + 32'(i) * 32'h0000_0101;
      v[0*32 +: 32] = 32'hAAAA_0001;
      v[1*32 +: 32] = 32'hBBBB_0002;
      v[2*32 +: 32] = 32'hCCCC_0003;
      v[3*32 +: 32] = 32'hDDDD_0004;
      return v;
   endfunction

   localparam logic [DEPTH*32-1:0] IMG = build_img();

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        Branch_taken = 1'b0;
   logic [31:0] Branch_Address = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_Instruction;
   logic        IF_ID_valid;
   logic [31:0] PC_out;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] Stall_count;
`endif

   fetch_stage #(
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (32'h0000_0000),
      .IMEM_INIT  (IMG)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .freeze            (freeze),
      .Branch_taken      (Branch_taken),
      .Branch_Address    (Branch_Address),
      .flush             (flush),
      .IF_ID_PC          (IF_ID_PC),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_valid       (IF_ID_valid),
      .PC_out            (PC_out)
`ifdef FETCH_STALL_CNT_EN
      ,
      .Stall_count       (Stall_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   // Behavioural model of the fetch rules
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_ifpc = 32'h0;
   logic [31:0] m_ifins = 32'h0;
   logic        m_ifv = 1'b0;
   logic [31:0] m_stall = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      int unsigned idx;
      idx = addr >> 2;
      if (idx < DEPTH) return IMG[idx*32 +: 32];
      return NOP;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifins = 32'h0; m_ifv = 1'b0; m_stall = 32'h0;
      end else begin
         logic [31:0] seq_pc;
         seq_pc = m_pc + 32'd4;
         if (flush) begin
            m_ifpc = 32'h0; m_ifins = 32'h0; m_ifv = 1'b0;
         end else if (!freeze) begin
            m_ifpc = seq_pc; m_ifins = mem_word(m_pc); m_ifv = 1'b1;
         end
         if (freeze && !Branch_taken && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (Branch_taken) m_pc = Branch_Address;
         else if (!freeze) m_pc = seq_pc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("pc_out", PC_out, m_pc);
      chk("if_id_pc", IF_ID_PC, m_ifpc);
      chk("if_id_instr", IF_ID_Instruction, m_ifins);
      chk("if_id_valid", {31'b0, IF_ID_valid}, {31'b0, m_ifv});
`ifdef FETCH_STALL_CNT_EN
      chk("stall_count", Stall_count, m_stall);
`endif
   endtask

   always @(negedge clk) if (chk_on) check_all();

   task automatic lit(input string name, input logic [31:0] ins, input logic [31:0] pc,
                      input logic vld, input logic [31:0] fetch_pc);
      chk({name, "_instr"}, IF_ID_Instruction, ins);
      chk({name, "_pc"}, IF_ID_PC, pc);
      chk({name, "_valid"}, {31'b0, IF_ID_valid}, {31'b0, vld});
      chk({name, "_fetch"}, PC_out, fetch_pc);
   endtask

   task automatic step(input logic fz, input logic br, input logic fl, input logic [31:0] ba);
      freeze = fz; Branch_taken = br; flush = fl; Branch_Address = ba;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      #1 chk_on = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      lit("reset", 32'h0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;

      // Sequential fetch A,B,C,D with a 3-cycle freeze on B
      step(0, 0, 0, 0); lit("seq_a", 32'hAAAA_0001, 32'd4, 1'b1, 32'd4);
      step(0, 0, 0, 0); lit("seq_b", 32'hBBBB_0002, 32'd8, 1'b1, 32'd8);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0); lit("frz_b", 32'hBBBB_0002, 32'd8, 1'b1, 32'd8);
      end
      step(0, 0, 0, 0); lit("seq_c", 32'hCCCC_0003, 32'd12, 1'b1, 32'd12);
      step(0, 0, 0, 0); lit("seq_d", 32'hDDDD_0004, 32'd16, 1'b1, 32'd16);

      // Branch with flush, then branch during freeze
      step(0, 1, 1, 32'h20); lit("br_bubble", 32'h0, 32'h0, 1'b0, 32'h20);
      step(0, 0, 0, 0);      lit("br_tgt", 32'h1234_0808, 32'h24, 1'b1, 32'h24);
      step(1, 1, 1, 32'h10); lit("frzbr_bubble", 32'h0, 32'h0, 1'b0, 32'h10);
      step(0, 0, 0, 0);      lit("frzbr_tgt", 32'h1234_0404, 32'h14, 1'b1, 32'h14);

      // Out-of-range target, unaligned target, PC wrap, flush+freeze
      step(0, 1, 1, 32'h40); lit("oor_bubble", 32'h0, 32'h0, 1'b0, 32'h40);
      step(0, 0, 0, 0);      lit("oor_nop", NOP, 32'h44, 1'b1, 32'h44);
      step(0, 1, 1, 32'h23); lit("unal_bubble", 32'h0, 32'h0, 1'b0, 32'h23);
      step(0, 0, 0, 0);      lit("unal_tgt", 32'h1234_0808, 32'h27, 1'b1, 32'h27);
      step(0, 1, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);      lit("wrap", NOP, 32'h0, 1'b1, 32'h0);
      step(1, 0, 1, 0);      lit("flush_frz", 32'h0, 32'h0, 1'b0, 32'h0);
      step(0, 0, 0, 0);      lit("after_flush", 32'hAAAA_0001, 32'd4, 1'b1, 32'd4);

      // Asynchronous reset in the middle of a freeze
      step(1, 0, 0, 0);
      #2 rst = 1'b0;
      #1 lit("async_rst", 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk); #1 rst = 1'b1;
      step(0, 0, 0, 0); lit("post_rst", 32'hAAAA_0001, 32'd4, 1'b1, 32'd4);

      // Five freezes, one overlapping a branch
      step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 32'h8);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt_4", Stall_count, 32'd4);
`endif
      chk("frz_after_br", PC_out, 32'h8);

      // Randomized control traffic
      for (int n = 0; n < 3000; n++) begin
         logic fz, br, fl;
         logic [31:0] ba;
         fz = ($urandom_range(0, 99) < 30);
         br = ($urandom_range(0, 99) < 15);
         fl = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : br;
         if ($urandom_range(0, 9) < 7)
            ba = (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
         else
            ba = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 1'b0;
            #1 check_all();
            @(negedge clk); #1 rst = 1'b1;
         end
         step(fz, br, fl, ba);
      end

      step(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
